// File: rtl/fft_r22sdf_bf.sv
// Radix-2^2 single-path delay-feedback butterfly stage: BF2I with L1 feedback delay,
// trivial -j rotation, BF2II with L2 feedback delay; 1/4 scaling across the stage.
module fft_r22sdf_bf #(
  parameter int DW    = 24,
  parameter int FFT_N = 1024,
  parameter int NLOG2 = 10,
  parameter int STAGE = 0
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             ce_i,
  input  logic [NLOG2-1:0] ctr_i,
  input  logic [DW-1:0]    x_re_i,
  input  logic [DW-1:0]    x_im_i,
  output logic [NLOG2-1:0] ctr_o,
  output logic [DW-1:0]    z_re_o,
  output logic [DW-1:0]    z_im_o,
  output logic             valid_o
);

  localparam int L1   = FFT_N >> (2*STAGE+1);
  localparam int L2   = FFT_N >> (2*STAGE+2);
  localparam int B1   = NLOG2-1-2*STAGE;
  localparam int B2   = NLOG2-2-2*STAGE;
  localparam int EW   = DW+2;
  localparam int FULL = L1+L2+2;

  localparam logic [NLOG2-1:0] L1W   = NLOG2'(L1);
  localparam logic [NLOG2-1:0] L2W   = NLOG2'(L2);
  localparam logic [NLOG2:0]   FULLW = (NLOG2+1)'(FULL);

  function automatic logic signed [EW-1:0] sx(input logic [DW-1:0] v);
    return EW'($signed(v));
  endfunction

  // Floor halving at extended width; the result always fits back into DW.
  function automatic logic [DW-1:0] half(input logic signed [EW-1:0] v);
    return DW'(v >>> 1);
  endfunction

  logic [DW-1:0] d1_re [L1];
  logic [DW-1:0] d1_im [L1];
  logic [DW-1:0] d2_re [L2];
  logic [DW-1:0] d2_im [L2];

  logic [DW-1:0]          r1_re, r1_im;
  logic [NLOG2-1:0]       c1;
  logic [NLOG2:0]         fill;

  logic signed [EW-1:0]   s1_re, s1_im, t1_re, t1_im;
  logic [DW-1:0]          out1_re, out1_im, push1_re, push1_im;
  logic                   rot;
  logic signed [EW-1:0]   y_re, y_im;
  logic signed [EW-1:0]   s2_re, s2_im, t2_re, t2_im;
  logic [DW-1:0]          out2_re, out2_im, push2_re, push2_im;

  always_comb begin
    s1_re    = sx(d1_re[L1-1]) + sx(x_re_i);
    s1_im    = sx(d1_im[L1-1]) + sx(x_im_i);
    t1_re    = sx(d1_re[L1-1]) - sx(x_re_i);
    t1_im    = sx(d1_im[L1-1]) - sx(x_im_i);
    out1_re  = d1_re[L1-1];
    out1_im  = d1_im[L1-1];
    push1_re = x_re_i;
    push1_im = x_im_i;
    if (ctr_i[B1]) begin
      out1_re  = half(s1_re);
      out1_im  = half(s1_im);
      push1_re = half(t1_re);
      push1_im = half(t1_im);
    end
  end

  // -(-2^(DW-1)) needs DW+1 bits; the rotated value is only ever summed, never stored raw.
  always_comb begin
    rot  = c1[B1] & c1[B2];
    y_re = rot ? sx(r1_im) : sx(r1_re);
    y_im = rot ? -sx(r1_re) : sx(r1_im);
  end

  always_comb begin
    s2_re    = sx(d2_re[L2-1]) + y_re;
    s2_im    = sx(d2_im[L2-1]) + y_im;
    t2_re    = sx(d2_re[L2-1]) - y_re;
    t2_im    = sx(d2_im[L2-1]) - y_im;
    out2_re  = d2_re[L2-1];
    out2_im  = d2_im[L2-1];
    push2_re = y_re[DW-1:0];
    push2_im = y_im[DW-1:0];
    if (c1[B2]) begin
      out2_re  = half(s2_re);
      out2_im  = half(s2_im);
      push2_re = half(t2_re);
      push2_im = half(t2_im);
    end
  end

  // Delay lines carry no reset; stale contents are hidden behind valid_o.
  always_ff @(posedge clk_i) begin
    if (ce_i) begin
      d1_re[0] <= push1_re;
      d1_im[0] <= push1_im;
      for (int unsigned i = 1; i < L1; i++) begin
        d1_re[i] <= d1_re[i-1];
        d1_im[i] <= d1_im[i-1];
      end
      d2_re[0] <= push2_re;
      d2_im[0] <= push2_im;
      for (int unsigned i = 1; i < L2; i++) begin
        d2_re[i] <= d2_re[i-1];
        d2_im[i] <= d2_im[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r1_re  <= '0;
      r1_im  <= '0;
      c1     <= '0;
      z_re_o <= '0;
      z_im_o <= '0;
      ctr_o  <= '0;
      fill   <= '0;
    end else if (ce_i) begin
      r1_re  <= out1_re;
      r1_im  <= out1_im;
      c1     <= ctr_i - L1W;
      z_re_o <= out2_re;
      z_im_o <= out2_im;
      ctr_o  <= c1 - L2W;
      if (fill != FULLW) fill <= fill + 1'b1;
    end
  end

  assign valid_o = (fill == FULLW);

endmodule

// File: tb/tb_fft_r22sdf_bf.sv
// Scoreboard bench for fft_r22sdf_bf (DW=16, FFT_N=16): expected outputs come from a
// frame-level radix-2^2 DIF model over the recorded input history.
module tb_fft_r22sdf_bf;

  localparam int LAT = 14;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce_i = 1'b0;
  logic [3:0]  ctr_i = '0;
  logic [15:0] x_re_i = '0, x_im_i = '0;
  logic [3:0]  ctr_o;
  logic [15:0] z_re_o, z_im_o;
  logic        valid_o;

  fft_r22sdf_bf #(.DW(16), .FFT_N(16), .NLOG2(4), .STAGE(0)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .ce_i(ce_i), .ctr_i(ctr_i),
    .x_re_i(x_re_i), .x_im_i(x_im_i),
    .ctr_o(ctr_o), .z_re_o(z_re_o), .z_im_o(z_im_o), .valid_o(valid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int c; int re; int im; } exp_t;
  exp_t sb[$];

  int hist_re [0:1023];
  int hist_im [0:1023];
  int p = 0;
  int since = 0;
  int vectors = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Frame-level DIF: a = halved BF2I pairs, -j on indices 12..15, then halved BF2II pairs.
  function automatic void model(input int q, output int zr, output int zi);
    int base, m;
    int ar[16], ai[16], yr[16], yi[16];
    base = (q / 16) * 16;
    m = q % 16;
    for (int k = 0; k < 8; k++) begin
      ar[k]   = (hist_re[base+k] + hist_re[base+k+8]) >>> 1;
      ai[k]   = (hist_im[base+k] + hist_im[base+k+8]) >>> 1;
      ar[k+8] = (hist_re[base+k] - hist_re[base+k+8]) >>> 1;
      ai[k+8] = (hist_im[base+k] - hist_im[base+k+8]) >>> 1;
    end
    for (int k = 0; k < 16; k++) begin
      if (k >= 12) begin yr[k] = ai[k]; yi[k] = -ar[k]; end
      else begin yr[k] = ar[k]; yi[k] = ai[k]; end
    end
    if ((m % 8) < 4) begin
      zr = (yr[m] + yr[m+4]) >>> 1;
      zi = (yi[m] + yi[m+4]) >>> 1;
    end else begin
      zr = (yr[m-4] - yr[m]) >>> 1;
      zi = (yi[m-4] - yi[m]) >>> 1;
    end
  endfunction

  task automatic step(input bit ce, input int re, input int im, input bit rst);
    exp_t e;
    bit   exp_v;
    int   zr, zi;
    logic [15:0] pre, pim;
    logic [3:0]  pc;
    logic        pv;
    @(negedge clk_i);
    ce_i   = ce;
    ctr_i  = 4'(p % 16);
    x_re_i = 16'(re);
    x_im_i = 16'(im);
    rst_n  = rst;
    if (!rst) begin
      #1;
      check_val("rst_z_re", int'(z_re_o), 0);
      check_val("rst_z_im", int'(z_im_o), 0);
      check_val("rst_ctr", int'(ctr_o), 0);
      check_val("rst_valid", int'(valid_o), 0);
    end
    pre = z_re_o; pim = z_im_o; pc = ctr_o; pv = valid_o;
    exp_v = 1'b0;
    if (!rst) since = 0;
    if (ce) begin
      hist_re[p] = re;
      hist_im[p] = im;
      if (rst) begin
        if (since < LAT) since++;
        if (since >= LAT) begin
          model(p - (LAT - 1), zr, zi);
          e.c = (p - (LAT - 1)) % 16;
          e.re = zr;
          e.im = zi;
          sb.push_back(e);
          exp_v = 1'b1;
        end
      end
      p++;
    end
    @(posedge clk_i);
    #1;
    if (!rst) begin
      check_val("rst_hold_z_re", int'(z_re_o), 0);
      check_val("rst_hold_valid", int'(valid_o), 0);
    end else if (!ce) begin
      check_val("stall_z_re", int'(z_re_o), int'(pre));
      check_val("stall_z_im", int'(z_im_o), int'(pim));
      check_val("stall_ctr", int'(ctr_o), int'(pc));
      check_val("stall_valid", int'(valid_o), int'(pv));
    end else begin
      check_val("valid", int'(valid_o), int'(exp_v));
      if (exp_v && sb.size() > 0) begin
        e = sb.pop_front();
        check_val("ctr_o", int'(ctr_o), e.c);
        check_val("z_re", int'($signed(z_re_o)), e.re);
        check_val("z_im", int'($signed(z_im_o)), e.im);
      end
    end
  endtask

  // mode 0 impulse@0, 1 impulse@12, 2 extremes, 3 DC 1000
  task automatic run_frames(input int mode, input int n, input bit stalls);
    int c, re, im;
    for (int i = 0; i < n * 16; i++) begin
      if (stalls && (i == 20 || $urandom_range(0, 15) == 0))
        for (int s = 0; s < 5; s++) step(1'b0, 0, 0, 1'b1);
      c = p % 16;
      re = 0; im = 0;
      case (mode)
        0: re = (c == 0) ? 16384 : 0;
        1: re = (c == 12) ? 4096 : 0;
        2: begin re = -32768; im = 32767; end
        default: re = 1000;
      endcase
      step(1'b1, re, im, 1'b1);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin hist_re[i] = 0; hist_im[i] = 0; end
    for (int i = 0; i < 20; i++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 65535) - 32768,
           $urandom_range(0, 65535) - 32768, 1'b0);
    run_frames(0, 5, 1'b0);
    run_frames(0, 5, 1'b1);
    run_frames(1, 3, 1'b0);
    run_frames(2, 3, 1'b0);
    run_frames(3, 2, 1'b0);
    while (p % 16 != 6) step(1'b1, 1000, 0, 1'b1);
    step(1'b1, 1000, 0, 1'b0);
    run_frames(3, 4, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule
